// File: rtl/sipo_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
//   Shared declarations for the serial-in/parallel-out deserializer slice.
//   - state_t       : FSM encoding (SHIFT collects data bits, PAR takes the
//                     optional parity bit)
//   - DEF_WIDTH     : default word width, matches the downstream 4-bit register
//   - DEF_MSB_FIRST : default bit order (0 = first received bit in bit 0)
// -----------------------------------------------------------------------------
package sipo_pkg;

    typedef enum logic {
        SHIFT = 1'b0,
        PAR   = 1'b1
    } state_t;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_MSB_FIRST = 0;

endpackage : sipo_pkg

// File: rtl/sipo_bit_counter.sv
// -----------------------------------------------------------------------------
// sipo_bit_counter
//   Counts accepted data bits of the word being assembled.
//   Ports:
//     clk   in   clock, rising edge
//     rst   in   synchronous, active-high reset (cnt -> 0)
//     inc   in   one data bit accepted this cycle
//     clr   in   word complete, restart at 0 (wins over inc)
//     cnt   out  number of data bits collected so far (0..WIDTH)
//     last  out  next data bit is the final data bit of the word
// -----------------------------------------------------------------------------
module sipo_bit_counter
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt  = r_cnt;
    assign last = (r_cnt == CNT_W'(WIDTH - 1));

endmodule : sipo_bit_counter

// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
//   Serial-in/parallel-out deserializer feeding the 4-bit parallel register.
//   Collects one bit per cycle from a valid/ready serial port into WIDTH-bit
//   words and presents them on a valid/ready parallel port through a one-word
//   output buffer. The next word keeps shifting in while an output word is
//   stalled; only the final slot of a word waits for the buffer to free up.
//
//   Optional feature (compile-time macro SIPO_PARITY_EN):
//     defined   : one extra even-parity bit follows each word; par_err flags
//                 ^{data, parity_bit} and loads together with out_data.
//     undefined : no parity slot, par_err is tied to 0.
//
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   synchronous, active-high reset
//     ser_in     in   serial data bit
//     ser_valid  in   ser_in valid this cycle
//     ser_ready  out  bit accepted when ser_valid && ser_ready
//     out_data   out  assembled word, stable while out_valid && !out_ready
//     out_valid  out  out_data holds an unconsumed word
//     out_ready  in   downstream takes the word when out_valid && out_ready
//     par_err    out  parity error of the current out_data (qualified by
//                     out_valid)
// -----------------------------------------------------------------------------
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MSB_FIRST = DEF_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic             ser_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             par_err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_next;
    logic [WIDTH-1:0]   w_word;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_valid;
    logic [CNT_W-1:0]   w_cnt;
    logic [CNT_W-1:0]   w_idx;
    logic               w_last;
    logic               w_accept;
    logic               w_final_slot;
    logic               w_data_acc;
    logic               w_load;

    sipo_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_data_acc),
        .clr  (w_load),
        .cnt  (w_cnt),
        .last (w_last)
    );

    assign w_accept = ser_valid && ser_ready;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SHIFT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
`ifdef SIPO_PARITY_EN
        case (r_state)
            SHIFT:   if (w_accept && w_last) w_state_next = PAR;
            PAR:     if (w_accept)           w_state_next = SHIFT;
            default: w_state_next = SHIFT;
        endcase
`else
        w_state_next = SHIFT;
`endif
    end

    // FSM: outputs. ser_ready depends combinationally on out_ready so the
    // final slot can complete on the very edge the pending word is taken.
    always_comb begin
`ifdef SIPO_PARITY_EN
        w_final_slot = (r_state == PAR);
`else
        w_final_slot = w_last;
`endif
        ser_ready  = !(w_final_slot && r_out_valid && !out_ready);
        w_data_acc = w_accept && (r_state == SHIFT);
        w_load     = w_accept && w_final_slot;
    end

    // Each data bit is written straight into its final position, selected by
    // the bit count, so no shifting is needed for either bit order.
    always_comb begin
        if (MSB_FIRST != 0) begin
            w_idx = CNT_W'(WIDTH - 1) - w_cnt;
        end else begin
            w_idx = w_cnt;
        end
        w_shift_next = r_shift;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_idx == CNT_W'(i)) begin
                w_shift_next[i] = ser_in;
            end
        end
    end

    // In parity mode the data bits are already complete when the parity bit
    // arrives; otherwise the word includes the bit being accepted now.
`ifdef SIPO_PARITY_EN
    assign w_word = r_shift;
`else
    assign w_word = w_shift_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_data_acc) begin
                r_shift <= w_shift_next;
            end
            // A load on the same edge as a consume keeps out_valid high.
            if (w_load) begin
                r_out_data  <= w_word;
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_EN
    logic r_par_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else if (w_load) begin
            r_par_err <= ^{r_shift, ser_in};
        end
    end

    assign par_err = r_par_err;
`else
    assign par_err = 1'b0;
`endif

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

endmodule : sipo_deserializer

// File: tb/tb_sipo_deserializer.sv
module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       ser_in;
    logic       ser_valid;
    logic       out_ready;
    logic       ser_ready;
    logic       out_valid;
    logic       par_err;
    logic [3:0] out_data;
    logic       ser_ready_m;
    logic       out_valid_m;
    logic       par_err_m;
    logic [3:0] out_data_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .par_err   (par_err)
    );

    sipo_deserializer #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
        .clk       (clk),
        .rst       (rst),
        .ser_in    (ser_in),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready_m),
        .out_data  (out_data_m),
        .out_valid (out_valid_m),
        .out_ready (out_ready),
        .par_err   (par_err_m)
    );

    task automatic drive_bit(input logic b);
        @(negedge clk);
        ser_valid = 1'b1;
        ser_in    = b;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        ser_valid = 1'b0;
        ser_in    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL reset_par_err got %b exp 0", par_err); end
        checks++; if (ser_ready !== 1'b1) begin errors++; $display("FAIL reset_ser_ready got %b exp 1", ser_ready); end
        checks++; if (out_valid_m !== 1'b0) begin errors++; $display("FAIL reset_out_valid_m got %b exp 0", out_valid_m); end
        checks++; if (ser_ready_m !== 1'b1) begin errors++; $display("FAIL reset_ser_ready_m got %b exp 1", ser_ready_m); end
        rst = 1'b0;
    endtask

    // Bits 1,0,1,1: LSB-first -> 1101, MSB-first -> 1011
    task automatic test_basic;
        out_ready = 1'b1;
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", out_valid); end
        @(negedge clk);
        ser_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== 4'b1101) begin errors++; $display("FAIL basic_data got %b exp 1101", out_data); end
        checks++; if (out_valid_m !== 1'b1) begin errors++; $display("FAIL msb_valid got %b exp 1", out_valid_m); end
        checks++; if (out_data_m !== 4'b1011) begin errors++; $display("FAIL msb_data got %b exp 1011", out_data_m); end
        checks++; if (par_err !== 1'b0 || par_err_m !== 1'b0) begin errors++; $display("FAIL basic_par_err got %b/%b exp 0/0", par_err, par_err_m); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got %b exp 0", out_valid); end
    endtask

    // 0xA then 0x5 LSB-first with the output stalled
    task automatic test_backpressure;
        out_ready = 1'b0;
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
        drive_bit(1'b0);
        #1;
        checks++; if (ser_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop got %b exp 0", ser_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== 4'hA) begin errors++; $display("FAIL bp_hold_a got %h exp a", out_data); end
        repeat (2) begin
            @(negedge clk);
            checks++; if (ser_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_stall got %b exp 0", ser_ready); end
            checks++; if (out_data !== 4'hA || out_valid !== 1'b1) begin errors++; $display("FAIL bp_stable got %h/%b exp a/1", out_data, out_valid); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (ser_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_comb got %b exp 1", ser_ready); end
        @(negedge clk);
        ser_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_stays got %b exp 1", out_valid); end
        checks++; if (out_data !== 4'h5) begin errors++; $display("FAIL bp_next_word got %h exp 5", out_data); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
    endtask

    // 16 random words, random serial gaps and random out_ready
    task automatic test_random;
        logic [3:0] words [16];
        logic [3:0] exp_q [$];
        int w, b, gap, got;
        logic acc, con;
        for (int i = 0; i < 16; i++) words[i] = 4'($urandom);
        w = 0; b = 0; gap = 0; got = 0;
        for (int cyc = 0; cyc < 3000 && got < 16; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_extra_word got %h exp none", out_data);
                end else if (out_data !== exp_q[0]) begin
                    errors++; $display("FAIL rand_word got %h exp %h", out_data, exp_q[0]);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (w < 16 && gap == 0) begin
                ser_valid = 1'b1;
                ser_in    = words[w][b];
            end else begin
                ser_valid = 1'b0;
                if (gap > 0) gap--;
            end
            #1;
            con = out_valid && out_ready;
            acc = ser_valid && ser_ready;
            if (con && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                got++;
            end
            if (acc) begin
                if (b == 3) begin
                    exp_q.push_back(words[w]);
                    w++;
                    b = 0;
                end else begin
                    b++;
                end
                gap = $urandom_range(0, 5);
            end
        end
        ser_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (got != 16 || exp_q.size() != 0) begin errors++; $display("FAIL rand_count got %0d exp 16", got); end
        @(negedge clk);
    endtask

    // Reset with a pending word and a partial word, then 0,1,1,0
    task automatic test_reset_midword;
        out_ready = 1'b0;
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1);
        drive_bit(1'b1); drive_bit(1'b1);
        @(negedge clk);
        ser_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 4'h9) begin errors++; $display("FAIL rst_pending got %h/%b exp 9/1", out_data, out_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_drop_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 4'h0) begin errors++; $display("FAIL rst_drop_data got %h exp 0", out_data); end
        out_ready = 1'b1;
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_partial_emit got %b exp 0", out_valid); end
        @(negedge clk);
        ser_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_word_valid got %b exp 1", out_valid); end
        checks++; if (out_data !== 4'b0110) begin errors++; $display("FAIL rst_word_data got %b exp 0110", out_data); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_word_once got %b exp 0", out_valid); end
    endtask

    // Data 1,1,0,0 then parity 1 (error) and parity 0 (clean)
    task automatic test_parity;
        out_ready = 1'b1;
        drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0);
        drive_bit(1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL par_early_valid got %b exp 0", out_valid); end
        @(negedge clk);
        ser_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 4'b0011) begin errors++; $display("FAIL par_data1 got %b/%b exp 0011/1", out_data, out_valid); end
        checks++; if (par_err !== 1'b1) begin errors++; $display("FAIL par_err_set got %b exp 1", par_err); end
        checks++; if (out_data_m !== 4'b1100 || par_err_m !== 1'b1) begin errors++; $display("FAIL par_msb got %b/%b exp 1100/1", out_data_m, par_err_m); end
        drive_bit(1'b1); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b0);
        drive_bit(1'b0);
        @(negedge clk);
        ser_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 4'b0011) begin errors++; $display("FAIL par_data2 got %b/%b exp 0011/1", out_data, out_valid); end
        checks++; if (par_err !== 1'b0) begin errors++; $display("FAIL par_err_clr got %b exp 0", par_err); end
    endtask

    initial begin
        test_reset();
`ifdef SIPO_PARITY_EN
        test_parity();
`else
        test_basic();
        test_backpressure();
        test_random();
        test_reset_midword();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout got running exp finished");
        $fatal(1, "watchdog");
    end

endmodule : tb_sipo_deserializer
